// File: rtl/calc_cmd_arbiter_if.sv
// Bus between the command arbiter, its two requesters and the calculator.
// A request transfers on a rising clock edge where valid and ready are both high; ready never waits on nothing but valid, and cmd is held stable while valid is high.
interface calc_cmd_arbiter_if;
  logic       req_a_valid;
  logic [3:0] req_a_cmd;
  logic       req_a_ready;
  logic       req_b_valid;
  logic [3:0] req_b_cmd;
  logic       req_b_ready;
  logic [1:0] calc_status;
  logic [3:0] calc_cmd;
  logic [1:0] grant;
  logic       busy;
  logic       err_calc;
  logic       err_timeout;
  logic       err_clr;
  logic [2:0] state;

  modport master (
    output req_a_valid, req_a_cmd, req_b_valid, req_b_cmd, calc_status, err_clr,
    input  req_a_ready, req_b_ready, calc_cmd, grant, busy, err_calc, err_timeout, state
  );

  modport slave (
    input  req_a_valid, req_a_cmd, req_b_valid, req_b_cmd, calc_status, err_clr,
    output req_a_ready, req_b_ready, calc_cmd, grant, busy, err_calc, err_timeout, state
  );
endinterface

// File: rtl/calc_cmd_arbiter.sv
// Round-robin arbiter sharing the calculator's 4-bit command input between two requesters.
// One command in flight at a time; issued as a single-cycle pulse, NOP otherwise.
module calc_cmd_arbiter #(
  parameter logic [3:0] NOP_CODE     = 4'hD,
  parameter int         ACK_TIMEOUT  = 8,
  parameter int         BUSY_TIMEOUT = 255
) (
  input logic          clock,
  input logic          reset,
  calc_cmd_arbiter_if.slave bus
);
  localparam int CNT_MAX_V = (ACK_TIMEOUT > BUSY_TIMEOUT) ? ACK_TIMEOUT : BUSY_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX_V + 1);
  localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_TIMEOUT);
  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_READY = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_inc;
  logic             ptr_b;
  logic [3:0]       cmd_reg;
  logic [1:0]       grant_reg;
  logic             err_calc_reg, err_timeout_reg;
  logic             calc_error, calc_ready;
  logic             pick_a, pick_b, ready_a, ready_b, accept;
  logic [3:0]       accept_cmd;
  logic             timeout_hit;

  assign calc_error = (bus.calc_status == ST_ERR);
  assign calc_ready = (bus.calc_status == ST_READY);
  assign count_inc  = (count == '1) ? count : count + 1'b1;

  // ptr_b set means A was served last, so B wins a tie
  assign pick_a = bus.req_a_valid && (!bus.req_b_valid || !ptr_b);
  assign pick_b = bus.req_b_valid && (!bus.req_a_valid || ptr_b);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state != HALT && calc_error) begin
      state_next = HALT;
    end else begin
      case (state)
        IDLE:      if (accept && accept_cmd != NOP_CODE) state_next = ISSUE;
        ISSUE:     state_next = WAIT_ACK;
        WAIT_ACK: begin
          if (!calc_ready)               state_next = WAIT_DONE;
          else if (count_inc == ACK_LIM) state_next = IDLE;
        end
        WAIT_DONE: begin
          if (calc_ready)                 state_next = IDLE;
          else if (count_inc == BUSY_LIM) state_next = HALT;
        end
        HALT:      if (bus.err_clr && !calc_error) state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_a     = (state == IDLE) && calc_ready && pick_a;
    ready_b     = (state == IDLE) && calc_ready && pick_b;
    accept      = ready_a || ready_b;
    accept_cmd  = ready_a ? bus.req_a_cmd : bus.req_b_cmd;
    timeout_hit = (state == WAIT_DONE) && !calc_error && !calc_ready && (count_inc == BUSY_LIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_reg         <= NOP_CODE;
      grant_reg       <= 2'b00;
      count           <= '0;
      ptr_b           <= 1'b0;
      err_calc_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      // calc_cmd carries the command only for the single ISSUE cycle
      cmd_reg <= (state_next == ISSUE) ? accept_cmd : NOP_CODE;

      if (state_next == IDLE || state_next == HALT) grant_reg <= 2'b00;
      else if (state_next == ISSUE)                 grant_reg <= {ready_b, ready_a};

      if ((state == WAIT_ACK  && state_next == WAIT_ACK) ||
          (state == WAIT_DONE && state_next == WAIT_DONE))
        count <= count_inc;
      else
        count <= '0;

      if (ready_a)      ptr_b <= 1'b1;
      else if (ready_b) ptr_b <= 1'b0;

      // a fresh error report wins over a simultaneous clear
      if (calc_error && (state != HALT || bus.err_clr)) err_calc_reg <= 1'b1;
      else if (bus.err_clr)                             err_calc_reg <= 1'b0;

      if (timeout_hit)      err_timeout_reg <= 1'b1;
      else if (bus.err_clr) err_timeout_reg <= 1'b0;
    end
  end

  assign bus.req_a_ready = ready_a;
  assign bus.req_b_ready = ready_b;
  assign bus.calc_cmd    = cmd_reg;
  assign bus.grant       = grant_reg;
  assign bus.busy        = (state != IDLE);
  assign bus.err_calc    = err_calc_reg;
  assign bus.err_timeout = err_timeout_reg;
  assign bus.state       = state;
endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Bench for calc_cmd_arbiter: drives both requesters and plays the calculator status,
// scoring every issued command against an expected queue.
module tb_calc_cmd_arbiter;
  localparam logic [3:0] NOP = 4'hD;
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WACK = 3'd2, S_WDONE = 3'd3, S_HALT = 3'd4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  calc_cmd_arbiter_if bus ();

  calc_cmd_arbiter #(.NOP_CODE(4'hD), .ACK_TIMEOUT(8), .BUSY_TIMEOUT(255)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // present one command for a single handshake; returns in the ISSUE cycle
  task automatic send(input bit is_b, input logic [3:0] cmd);
    if (is_b) begin bus.req_b_valid = 1'b1; bus.req_b_cmd = cmd; end
    else      begin bus.req_a_valid = 1'b1; bus.req_a_cmd = cmd; end
    #1;
    check(is_b ? "send_b_ready" : "send_a_ready", is_b ? bus.req_b_ready : bus.req_a_ready, 1'b1);
    tick();
    bus.req_a_valid = 1'b0;
    bus.req_b_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (bus.state == s) break;
      tick();
    end
    check(tag, bus.state, s);
  endtask

  always @(negedge clock) begin
    if (bus.calc_cmd != NOP) begin
      if (exp_q.size() == 0) check("unexpected_cmd", bus.calc_cmd, NOP);
      else                   check("issue_cmd", bus.calc_cmd, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g[4];
    logic [1:0] prev_g;
    bit found;

    bus.req_a_valid = 1'b0; bus.req_a_cmd = 4'h0;
    bus.req_b_valid = 1'b0; bus.req_b_cmd = 4'h0;
    bus.calc_status = 2'b10;
    bus.err_clr     = 1'b0;
    tick();
    do_reset();
    check("rst_state", bus.state, S_IDLE);
    check("rst_cmd", bus.calc_cmd, NOP);
    check("rst_grant", bus.grant, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_errs", {bus.err_calc, bus.err_timeout}, 2'b00);

    // A alone: pulse of 7, print phase of 9 cycles
    exp_q.push_back(4'h7);
    send(1'b0, 4'h7);
    check("t1_state_issue", bus.state, S_ISSUE);
    check("t1_grant_issue", bus.grant, 2'b01);
    bus.calc_status = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) check("t1_pulse_one_cycle", bus.calc_cmd, NOP);
      check("t1_grant_hold", bus.grant, 2'b01);
    end
    tick();
    check("t1_wait_done", bus.state, S_WDONE);
    bus.calc_status = 2'b10;
    tick();
    check("t1_idle", bus.state, S_IDLE);
    check("t1_grant_clr", bus.grant, 2'b00);
    check("t1_busy_clr", bus.busy, 1'b0);

    // both requesters valid: strict alternation starting with A after reset
    do_reset();
    bus.calc_status = 2'b10;
    bus.req_a_valid = 1'b1; bus.req_a_cmd = 4'h3;
    bus.req_b_valid = 1'b1; bus.req_b_cmd = 4'h5;
    exp_q.push_back(4'h3); exp_q.push_back(4'h5);
    exp_q.push_back(4'h3); exp_q.push_back(4'h5);
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    prev_g = 2'b00;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (bus.calc_cmd != NOP) begin found = 1'b1; break; end
      end
      check("rr_seen", found, 1'b1);
      check("rr_grant", bus.grant, exp_g[k]);
      check("rr_alternate", bus.grant != prev_g, 1'b1);
      prev_g = bus.grant;
      if (k == 3) begin bus.req_a_valid = 1'b0; bus.req_b_valid = 1'b0; end
      bus.calc_status = 2'b01;
      repeat (4) tick();
      bus.calc_status = 2'b10;
    end
    wait_state(S_IDLE, 20, "rr_idle");

    // B busy for 200 cycles: no timeout
    exp_q.push_back(4'hC);
    send(1'b1, 4'hC);
    bus.calc_status = 2'b01;
    repeat (200) tick();
    check("t3_still_wait", bus.state, S_WDONE);
    check("t3_no_timeout", bus.err_timeout, 1'b0);
    bus.calc_status = 2'b10;
    tick();
    check("t3_idle", bus.state, S_IDLE);

    // B busy for 300 cycles: HALT after 255 cycles in WAIT_DONE
    exp_q.push_back(4'hC);
    send(1'b1, 4'hC);
    bus.calc_status = 2'b01;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 256) check("to_before", bus.state, S_WDONE);
      if (i == 257) begin
        check("to_halt", bus.state, S_HALT);
        check("to_flag", bus.err_timeout, 1'b1);
        check("to_no_calc_err", bus.err_calc, 1'b0);
        check("to_grant", bus.grant, 2'b00);
        check("to_busy", bus.busy, 1'b1);
      end
    end
    check("to_halt_held", bus.state, S_HALT);
    bus.calc_status = 2'b10;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("to_clr_idle", bus.state, S_IDLE);
    check("to_clr_flag", bus.err_timeout, 1'b0);

    // A with status stuck at READY: absorbed after 8 WAIT_ACK cycles
    exp_q.push_back(4'hA);
    send(1'b0, 4'hA);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 8) check("ack_last_wait", bus.state, S_WACK);
      if (i == 9) begin
        check("ack_idle", bus.state, S_IDLE);
        check("ack_no_err", {bus.err_calc, bus.err_timeout}, 2'b00);
      end
    end

    // calculator error during WAIT_DONE
    exp_q.push_back(4'h1);
    send(1'b0, 4'h1);
    bus.calc_status = 2'b01;
    tick();
    tick();
    check("ce_wait_done", bus.state, S_WDONE);
    bus.calc_status = 2'b00;
    bus.req_a_valid = 1'b1; bus.req_a_cmd = 4'h4;
    bus.req_b_valid = 1'b1; bus.req_b_cmd = 4'h6;
    tick();
    check("ce_halt", bus.state, S_HALT);
    check("ce_flag", bus.err_calc, 1'b1);
    check("ce_no_timeout", bus.err_timeout, 1'b0);
    bus.calc_status = 2'b10;
    #1;
    check("ce_ready_low", {bus.req_a_ready, bus.req_b_ready}, 2'b00);
    tick();
    check("ce_halt_held", bus.state, S_HALT);
    bus.err_clr = 1'b1;
    bus.calc_status = 2'b00;
    tick();
    check("ce_clr_while_err_state", bus.state, S_HALT);
    check("ce_clr_while_err_flag", bus.err_calc, 1'b1);
    bus.req_a_valid = 1'b0; bus.req_b_valid = 1'b0;
    bus.calc_status = 2'b10;
    tick();
    bus.err_clr = 1'b0;
    check("ce_clr_idle", bus.state, S_IDLE);
    check("ce_clr_flags", {bus.err_calc, bus.err_timeout}, 2'b00);

    // reset during WAIT_DONE, then a NOP request and the pointer after it
    exp_q.push_back(4'h2);
    send(1'b0, 4'h2);
    bus.calc_status = 2'b01;
    tick();
    tick();
    check("rm_wait_done", bus.state, S_WDONE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm_idle", bus.state, S_IDLE);
    check("rm_cmd", bus.calc_cmd, NOP);
    check("rm_grant", bus.grant, 2'b00);
    check("rm_busy", bus.busy, 1'b0);
    bus.calc_status = 2'b10;
    bus.req_a_valid = 1'b1; bus.req_a_cmd = NOP;
    bus.req_b_valid = 1'b1; bus.req_b_cmd = 4'h6;
    #1;
    check("rm_ptr_favours_a", {bus.req_a_ready, bus.req_b_ready}, 2'b10);
    tick();
    check("nop_stay_idle", bus.state, S_IDLE);
    check("nop_cmd", bus.calc_cmd, NOP);
    check("nop_grant", bus.grant, 2'b00);
    #1;
    check("nop_ptr_moves_b", {bus.req_a_ready, bus.req_b_ready}, 2'b01);
    exp_q.push_back(4'h6);
    tick();
    bus.req_a_valid = 1'b0; bus.req_b_valid = 1'b0;
    check("nop_then_issue", bus.state, S_ISSUE);
    wait_state(S_IDLE, 20, "nop_final_idle");

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_cmd_arbiter.md
Name: calc_cmd_arbiter

Overview:
- Shares the calculator's single 4-bit command input between two requesters: A (keypad scanner) and B (serial/debug injector).
- Issues exactly one command at a time as a one-cycle pulse, only when the calculator reports READY.
- Waits for the calculator's busy/print phase to finish before issuing the next command.
- Drives the NOP code on the command bus at all other times; detects calculator errors and stalls; halts until software clears.

Parameters:
- NOP_CODE, 4'hD, idle command code; the calculator ignores it (0-9 digits, A-C operators, E '=', F backspace).
- ACK_TIMEOUT, 8, cycles to wait in WAIT_ACK for status to leave READY before the command counts as silently absorbed.
- BUSY_TIMEOUT, 255, maximum cycles in WAIT_DONE before a timeout error.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_a_valid  in  1  requester A has a command
- req_a_cmd  in  4  requester A command code
- req_a_ready  out  1  A command accepted this cycle (combinational)
- req_b_valid  in  1  requester B has a command
- req_b_cmd  in  4  requester B command code
- req_b_ready  out  1  B command accepted this cycle (combinational)
- calc_status  in  2  calculator status: 00 error, 01 busy, 10 ready, 11 printing
- calc_cmd  out  4  registered command to calculator
- grant  out  2  one-hot owner of the in-flight command; 00 when idle
- busy  out  1  high in any state except IDLE
- err_calc  out  1  sticky: calculator reported status 00
- err_timeout  out  1  sticky: BUSY_TIMEOUT expired
- err_clr  in  1  clears both error flags and releases HALT

Behaviour:
- Reset (synchronous, active-high; the only reset): state=IDLE, calc_cmd=NOP_CODE, grant=00, busy=0, both error flags=0, counter=0, round-robin pointer favours A.
- Handshake: a transfer occurs on valid & ready in the same cycle.
  - ready is high only in IDLE with calc_status==10, for at most one requester per cycle.
  - Requesters hold cmd stable while valid is high.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, HALT.
- IDLE:
  - calc_cmd=NOP_CODE.
  - If calc_status==10 and any valid: grant the single valid requester; if both are valid, grant the one not served last (round-robin).
  - Assert its ready, latch its cmd, set grant, update the pointer, go to ISSUE.
  - If the latched cmd equals NOP_CODE: accept and drop it; pointer still updates; stay in IDLE with grant=00.
- ISSUE: calc_cmd=latched cmd for exactly one cycle (calc_cmd is valid the cycle after acceptance). Counter cleared. Next state WAIT_ACK.
- WAIT_ACK:
  - calc_cmd=NOP_CODE; counter increments.
  - calc_status!=10 -> WAIT_DONE, counter cleared.
  - Counter==ACK_TIMEOUT with status still 10 -> IDLE, no error.
- WAIT_DONE:
  - Counter increments.
  - calc_status==10 -> IDLE, grant=00.
  - Counter==BUSY_TIMEOUT -> HALT, err_timeout=1.
- HALT:
  - calc_cmd=NOP_CODE; both ready low; grant=00.
  - err_clr=1 -> IDLE next cycle, both flags cleared.
- Error detection, any state except HALT: calc_status==00 -> HALT next cycle, err_calc=1. This has priority over all other transitions.
- Simultaneous events:
  - err_clr in HALT while calc_status==00: flags clear, but err_calc sets again and the FSM stays in HALT.
  - err_clr outside HALT clears the flags only.
- Reset mid-operation: any in-flight command is abandoned. Requesters see no ready, calc_cmd returns to NOP_CODE on the next edge, and the pointer favours A.
- Counter width: clog2(max(ACK_TIMEOUT, BUSY_TIMEOUT)+1) bits; it saturates and never wraps.
- Only one command is ever outstanding. No queuing inside the block.

Test Plan:
- A alone sends 4'h7 with status=10 -> req_a_ready high 1 cycle; calc_cmd=7 exactly 1 cycle later; status 11 for 9 cycles then 10 -> returns to IDLE; grant=01 throughout, then 00.
- A and B both valid continuously (A=3, B=5), status returns to 10 after 4 cycles each time -> issue order 3,5,3,5; never two consecutive grants to the same requester.
- B sends 4'hC, status held 01 for 200 cycles -> no timeout; IDLE on return to 10. Same with 300 busy cycles -> HALT after 255 cycles, err_timeout=1; err_clr -> IDLE.
- A sends 4'hA, status stays 10 -> back to IDLE after 8 WAIT_ACK cycles; err flags stay 0.
- status forced 00 during WAIT_DONE -> HALT next cycle, err_calc=1, ready low despite valids; err_clr with status=10 -> IDLE and flags 0.
- reset pulsed during WAIT_DONE -> next cycle IDLE, calc_cmd=4'hD, grant=00. A sends NOP_CODE 4'hD -> ready pulse, calc_cmd stays 4'hD, no ISSUE.
